// File: rtl/counter_ramp_ctrl.sv
// counter_ramp_ctrl: steps an external up/down counter to a commanded target at a programmable rate
module counter_ramp_ctrl #(
  parameter int LENGTH    = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LENGTH-1:0]    cmd_target,
  input  logic [DIV_WIDTH-1:0] cmd_div,
  input  logic                 abort,
  input  logic [LENGTH-1:0]    ctr_value,
  output logic                 ctr_enable,
  output logic                 ctr_up_down,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);
  typedef enum logic [1:0] {IDLE, DECIDE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [LENGTH-1:0] target_q, target_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, pre_q, pre_d;
  logic enable_q, enable_d, up_q, up_d, busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  assign cmd_ready   = state_q == IDLE;
  assign ctr_enable  = enable_q;
  assign ctr_up_down = up_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    div_d     = div_q;
    pre_d     = pre_q;
    enable_d  = 1'b0;
    up_d      = up_q;
    done_d    = state_q == DONE;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        target_d = cmd_target;
        div_d    = cmd_div;
        state_d  = DECIDE;
      end
      DECIDE: if (abort) begin
        aborted_d = 1'b1;
        state_d   = IDLE;
      end else if (ctr_value == target_q) begin
        state_d = DONE;
      end else begin
        enable_d = 1'b1;
        up_d     = target_q > ctr_value;
        pre_d    = div_q;
        state_d  = WAIT;
      end
      WAIT: if (abort) begin
        aborted_d = 1'b1;
        state_d   = IDLE;
      end else if (pre_q == '0) begin
        state_d = DECIDE;
      end else begin
        pre_d = pre_q - DIV_WIDTH'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      div_q     <= '0;
      pre_q     <= '0;
      enable_q  <= 1'b0;
      up_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      div_q     <= div_d;
      pre_q     <= pre_d;
      enable_q  <= enable_d;
      up_q      <= up_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end
endmodule
